// File: rtl/processor_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit processor: two-byte instruction
// fetch from ROM, mov (RAM -> register) and conditional relative jump.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH_HI  | latch high instruction byte from ROM, advance ip
// FETCH_LO  | latch low instruction byte from ROM, advance ip
// EXECUTE   | mov: issue RAM read; js: branch on sign flag; illegal: retire
// WRITEBACK | write returned RAM byte into the destination register
module processor_control_unit #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SIGN_BIT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_rd_en,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  input  logic [DATA_WIDTH-1:0]    flags,
  output logic                     reg_wr_en,
  output logic [3:0]               reg_wr_addr,
  output logic [DATA_WIDTH-1:0]    reg_wr_data,
  output logic [ADDRESS_WIDTH-1:0] ip,
  output logic                     instr_done,
  output logic                     illegal_op,
  output logic [1:0]               state
);

  localparam int IW = 2 * DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] IP_STEP = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {
    FETCH_HI  = 2'd0,
    FETCH_LO  = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t                   cur_state;
  state_t                   nxt_state;
  logic [DATA_WIDTH-1:0]    ir_hi;
  logic [DATA_WIDTH-1:0]    ir_lo;
  logic [IW-1:0]            ir;
  logic [ADDRESS_WIDTH-1:0] ip_q;
  logic [ADDRESS_WIDTH-1:0] ir_field;
  logic [1:0]               opcode;
  logic                     is_mov;
  logic                     is_js;
  logic                     is_illegal;
  logic                     branch_taken;
  logic                     active;
  logic                     unused_bits;

  assign ir           = {ir_hi, ir_lo};
  assign opcode       = ir[IW-1 -: 2];
  assign is_mov       = (opcode == 2'b00);
  assign is_js        = (opcode == 2'b01);
  assign is_illegal   = opcode[1];
  // RAM address for mov and branch offset for js share the low IR bits.
  assign ir_field     = ir[ADDRESS_WIDTH-1:0];
  assign branch_taken = is_js && flags[SIGN_BIT];
  assign active       = !rst && !stall;
  assign unused_bits  = ^{flags, ir};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH_HI;
    end else if (!stall) begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      FETCH_HI:  nxt_state = FETCH_LO;
      FETCH_LO:  nxt_state = EXECUTE;
      EXECUTE:   nxt_state = is_mov ? WRITEBACK : FETCH_HI;
      WRITEBACK: nxt_state = FETCH_HI;
      default:   nxt_state = FETCH_HI;
    endcase
  end

  // Instruction register and instruction pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ip_q  <= '0;
      ir_hi <= '0;
      ir_lo <= '0;
    end else if (!stall) begin
      case (cur_state)
        FETCH_HI: begin
          ir_hi <= rom_data;
          ip_q  <= ip_q + IP_STEP;
        end
        FETCH_LO: begin
          ir_lo <= rom_data;
          ip_q  <= ip_q + IP_STEP;
        end
        EXECUTE: begin
          // ip already points past the js, so the offset is relative to instr+2.
          if (branch_taken) begin
            ip_q <= ip_q + ir_field;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: strobes only fire on live (unstalled, not in reset) cycles
  always_comb begin
    ram_rd_en   = 1'b0;
    reg_wr_en   = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    reg_wr_data = '0;
    if (cur_state == WRITEBACK) begin
      reg_wr_data = ram_rdata;
    end
    if (active) begin
      case (cur_state)
        EXECUTE: begin
          if (is_mov) begin
            ram_rd_en = 1'b1;
          end else begin
            instr_done = 1'b1;
            illegal_op = is_illegal;
          end
        end
        WRITEBACK: begin
          reg_wr_en  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr    = ir_field;
  assign reg_wr_addr = ir[13:10];
  assign rom_addr    = ip_q;
  assign ip          = ip_q;
  assign state       = cur_state;

endmodule

// File: tb/tb_processor_control_unit.sv
// Bench for processor_control_unit: instruction-level reference model compared
// every cycle, directed programs with literal expectations, then random traffic.
module tb_processor_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] ram_addr;
  logic       ram_rd_en;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] flags;
  logic       reg_wr_en;
  logic [3:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [3:0] ip;
  logic       instr_done;
  logic       illegal_op;
  logic [1:0] state;

  logic [7:0] rom [16];
  logic [7:0] ram [16];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int ill_cnt = 0;
  logic chk_en = 1'b0;

  // Model: address of the instruction in flight and cycle index within it.
  logic [3:0] m_a = 4'd0;
  int         m_k = 0;

  processor_control_unit #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8), .SIGN_BIT(0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
    .flags(flags),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .ip(ip), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Instruction-level model: mov takes 4 cycles, everything else 3.
  always @(posedge clk) begin
    if (rst) begin
      m_a <= 4'd0;
      m_k <= 0;
    end else if (!stall) begin
      if (m_k == 2 && rom[m_a][7:6] != 2'b00) begin
        m_a <= m_a + 4'd2 +
               ((rom[m_a][7:6] == 2'b01 && flags[0]) ? rom[m_a + 4'd1][3:0] : 4'd0);
        m_k <= 0;
      end else if (m_k == 3) begin
        m_a <= m_a + 4'd2;
        m_k <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] eip;
    logic       live;
    logic       mov;
    logic       e_rd;
    logic       e_wr;
    hi   = rom[m_a];
    lo   = rom[m_a + 4'd1];
    mov  = (hi[7:6] == 2'b00);
    live = !rst && !stall;
    eip  = (m_k == 0) ? m_a : (m_k == 1) ? m_a + 4'd1 : m_a + 4'd2;
    e_rd = live && m_k == 2 && mov;
    e_wr = live && m_k == 3;
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_k));
      chk("ip", 32'(ip), 32'(eip));
      chk("rom_addr", 32'(rom_addr), 32'(eip));
      chk("ram_rd_en", 32'(ram_rd_en), 32'(e_rd));
      chk("reg_wr_en", 32'(reg_wr_en), 32'(e_wr));
      chk("instr_done", 32'(instr_done), 32'(e_wr || (live && m_k == 2 && !mov)));
      chk("illegal_op", 32'(illegal_op), 32'(live && m_k == 2 && hi[7]));
      if (e_rd) chk("ram_addr", 32'(ram_addr), 32'(lo[3:0]));
      if (e_wr) begin
        chk("reg_wr_addr", 32'(reg_wr_addr), 32'(hi[5:2]));
        chk("reg_wr_data", 32'(reg_wr_data), 32'(ram[lo[3:0]]));
      end
    end
    if (reg_wr_en === 1'b1) wr_cnt++;
    if (illegal_op === 1'b1) ill_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h00;
      ram[i] = 8'h00;
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flags = 8'h00;

    // Program A: mov, taken js, untaken js, mov
    clear_mem();
    rom[0] = 8'h0C; rom[1] = 8'h04; rom[2] = 8'h40; rom[3] = 8'h05;
    rom[9] = 8'h40; rom[10] = 8'h07; rom[11] = 8'h08; rom[12] = 8'h02;
    ram[4] = 8'h06; ram[2] = 8'h1E;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    for (int n = 0; n < 14; n++) begin
      flags = (n < 7) ? 8'h03 : 8'h00;
      #1;
      if (n == 0) begin
        chk("a_rst_state", 32'(state), 0);
        chk("a_rst_ip", 32'(ip), 0);
        chk("a_rst_wr", 32'(reg_wr_en), 0);
      end
      if (n == 3) begin
        chk("a_mov_wr", 32'(reg_wr_en), 1);
        chk("a_mov_addr", 32'(reg_wr_addr), 3);
        chk("a_mov_data", 32'(reg_wr_data), 32'h06);
        chk("a_mov_ip", 32'(ip), 2);
      end
      if (n == 6) chk("a_js_done", 32'(instr_done), 1);
      if (n == 7) chk("a_js_taken_ip", 32'(ip), 9);
      if (n == 10) chk("a_js_nt_ip", 32'(ip), 11);
      if (n == 13) begin
        chk("a_mov2_addr", 32'(reg_wr_addr), 2);
        chk("a_mov2_data", 32'(reg_wr_data), 32'h1E);
      end
      tick();
    end
    chk("a_end_ip", 32'(ip), 13);

    // Program B: address wrap on branch and on instruction fetch
    rst = 1'b1;
    clear_mem();
    rom[0] = 8'h40; rom[1] = 8'h0C; rom[3] = 8'h40; rom[4] = 8'h0A;
    rom[14] = 8'h40; rom[15] = 8'h03;
    ram[0] = 8'h5A;
    tick(); tick();
    rst = 1'b0;
    flags = 8'h01;
    for (int n = 0; n < 13; n++) begin
      #1;
      if (n == 3) chk("b_ip14", 32'(ip), 14);
      if (n == 6) chk("b_wrap_ip", 32'(ip), 3);
      if (n == 9) chk("b_ip15", 32'(ip), 15);
      if (n == 10) chk("b_lo_from0", 32'(rom_addr), 0);
      if (n == 12) begin
        chk("b_wr_addr", 32'(reg_wr_addr), 0);
        chk("b_wr_data", 32'(reg_wr_data), 32'h5A);
      end
      tick();
    end
    chk("b_end_ip", 32'(ip), 1);

    // Program C: stalled writeback, illegal op, reset during writeback
    rst = 1'b1;
    clear_mem();
    rom[0] = 8'h0C; rom[1] = 8'h04; rom[2] = 8'h80; rom[3] = 8'h00;
    rom[4] = 8'h0C; rom[5] = 8'h04;
    ram[4] = 8'h06;
    flags = 8'h00;
    tick(); tick();
    rst = 1'b0;
    wr_cnt = 0;
    ill_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      stall = (n >= 3 && n <= 5);
      rst = (n == 13 || n == 14);
      #1;
      if (n == 4) begin
        chk("c_stall_state", 32'(state), 3);
        chk("c_stall_wr", 32'(reg_wr_en), 0);
      end
      if (n == 6) begin
        chk("c_wr_after_stall", 32'(reg_wr_en), 1);
        chk("c_wr_data", 32'(reg_wr_data), 32'h06);
      end
      if (n == 9) chk("c_illegal", 32'(illegal_op), 1);
      if (n == 10) chk("c_ill_ip", 32'(ip), 4);
      if (n == 13) chk("c_rst_nowr", 32'(reg_wr_en), 0);
      if (n == 15) begin
        chk("c_post_rst_state", 32'(state), 0);
        chk("c_post_rst_ip", 32'(ip), 0);
        chk("c_post_rst_wr", 32'(reg_wr_en), 0);
        chk("c_post_rst_waddr", 32'(reg_wr_addr), 0);
        chk("c_post_rst_wdata", 32'(reg_wr_data), 0);
      end
      tick();
    end
    chk("c_write_count", 32'(wr_cnt), 1);
    chk("c_illegal_count", 32'(ill_cnt), 1);
    stall = 1'b0;

    // Random programs, flags, stalls and resets
    for (int ep = 0; ep < 4; ep++) begin
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom);
        ram[i] = 8'($urandom);
      end
      tick(); tick();
      rst = 1'b0;
      for (int n = 0; n < 400; n++) begin
        stall = ($urandom_range(0, 4) == 0);
        flags = 8'($urandom);
        rst = ($urandom_range(0, 63) == 0);
        tick();
      end
    end
    rst = 1'b0;
    stall = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
